// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: redirect input, instruction-memory
// request/response channel and the decode-facing instruction channel.
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            redirect_valid;
  logic            pc_src;
  logic [XLEN-1:0] target_addr;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;

  modport master (
    input  redirect_valid, pc_src, target_addr,
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    output inst_valid, inst, inst_pc,
    input  inst_ready
  );

  modport slave (
    output redirect_valid, pc_src, target_addr,
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    input  inst_valid, inst, inst_pc,
    output inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// PC register and single-outstanding instruction fetch stage.
// Buffers one instruction for decode; taken redirects flush it.
module fetch_unit #(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset_n,
  fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_discard;
  logic            r_inst_valid;
  logic [XLEN-1:0] r_inst;
  logic [XLEN-1:0] r_inst_pc;

  state_t          w_state_nxt;
  logic [XLEN-1:0] w_pc_nxt;
  logic            w_discard_nxt;
  logic            w_iv_nxt;
  logic [XLEN-1:0] w_inst_nxt;
  logic [XLEN-1:0] w_ipc_nxt;
  logic            w_req_valid;
  logic            w_redir;
  logic [XLEN-1:0] w_tgt;

  assign w_redir = bus.redirect_valid & bus.pc_src;
  assign w_tgt   = {bus.target_addr[XLEN-1:2], 2'b00};

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_pc;
  assign bus.inst_valid     = r_inst_valid;
  assign bus.inst           = r_inst;
  assign bus.inst_pc        = r_inst_pc;

  // Next-state and request logic; redirect overrides handshake/response.
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_discard_nxt = r_discard;
    w_iv_nxt      = r_inst_valid;
    w_inst_nxt    = r_inst;
    w_ipc_nxt     = r_inst_pc;
    w_req_valid   = 1'b0;
    unique case (r_state)
      S_REQ: begin
        w_req_valid = reset_n;
        if (w_req_valid && bus.imem_req_ready) begin
          w_pc_nxt      = r_pc + XLEN'(4);
          w_state_nxt   = S_WAIT;
          w_discard_nxt = w_redir;
        end
        if (w_redir) begin
          w_pc_nxt = w_tgt;
        end
      end
      S_WAIT: begin
        if (bus.imem_rsp_valid) begin
          if (r_discard || w_redir) begin
            w_discard_nxt = 1'b0;
            w_state_nxt   = S_REQ;
            if (w_redir) begin
              w_pc_nxt = w_tgt;
            end
          end else begin
            w_inst_nxt  = bus.imem_rsp_data;
            w_ipc_nxt   = r_pc - XLEN'(4);
            w_iv_nxt    = 1'b1;
            w_state_nxt = S_HOLD;
          end
        end else if (w_redir) begin
          w_discard_nxt = 1'b1;
          w_pc_nxt      = w_tgt;
        end
      end
      S_HOLD: begin
        if (w_redir) begin
          w_iv_nxt    = 1'b0;
          w_pc_nxt    = w_tgt;
          w_state_nxt = S_REQ;
        end else if (bus.inst_ready) begin
          w_iv_nxt    = 1'b0;
          w_state_nxt = S_REQ;
        end
      end
      default: begin
        w_state_nxt = S_REQ;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= S_REQ;
      r_pc         <= XLEN'(RESET_PC);
      r_discard    <= 1'b0;
      r_inst_valid <= 1'b0;
      r_inst       <= '0;
      r_inst_pc    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_discard    <= w_discard_nxt;
      r_inst_valid <= w_iv_nxt;
      r_inst       <= w_inst_nxt;
      r_inst_pc    <= w_ipc_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector bench for fetch_unit: one table row per clock cycle
// plus a reactive-memory throughput sequence.
module tb_fetch_unit;

  logic clk;
  logic reset_n;

  fetch_unit_if #(.XLEN(32)) bus ();

  fetch_unit #(
    .XLEN    (32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rv;
    logic        ps;
    logic [31:0] tgt;
    logic        rdy;
    logic        rspv;
    logic [31:0] rspd;
    logic        irdy;
    logic        e_rqv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_inst;
    logic [31:0] e_ipc;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int row    = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d got %h expected %h", nm, row, act, exp);
    end
  endtask

  function automatic vec_t mk(
    logic rst, logic rv, logic ps, logic [31:0] tgt, logic rdy,
    logic rspv, logic [31:0] rspd, logic irdy,
    logic e_rqv, logic [31:0] e_addr, logic e_iv,
    logic [31:0] e_inst, logic [31:0] e_ipc);
    vec_t v;
    v.rst = rst; v.rv = rv; v.ps = ps; v.tgt = tgt; v.rdy = rdy;
    v.rspv = rspv; v.rspd = rspd; v.irdy = irdy;
    v.e_rqv = e_rqv; v.e_addr = e_addr; v.e_iv = e_iv;
    v.e_inst = e_inst; v.e_ipc = e_ipc;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    logic        pend;
    logic [31:0] paddr;
    logic [31:0] exp_pc;
    int          nvalid;

    // rst rv ps tgt rdy rspv rspd irdy | rqv addr iv inst ipc
    tbl.push_back(mk(0,0,0,0,1,0,0,1, 0,32'h0,0,32'h0,32'h0));
    tbl.push_back(mk(1,0,0,0,1,0,0,1, 1,32'h0,0,32'h0,32'h0));
    tbl.push_back(mk(1,0,0,0,1,1,32'h11111111,1,
                     0,32'h4,0,32'h0,32'h0));
    tbl.push_back(mk(1,0,0,0,1,0,0,1,
                     0,32'h4,1,32'h11111111,32'h0));
    tbl.push_back(mk(1,0,0,0,1,0,0,1,
                     1,32'h4,0,32'h11111111,32'h0));
    tbl.push_back(mk(1,0,0,0,1,1,32'h22222222,1,
                     0,32'h8,0,32'h11111111,32'h0));
    tbl.push_back(mk(1,0,0,0,1,0,0,1,
                     0,32'h8,1,32'h22222222,32'h4));
    tbl.push_back(mk(1,0,0,0,1,0,0,1,
                     1,32'h8,0,32'h22222222,32'h4));
    // redirect in WAIT, response next cycle is dropped
    tbl.push_back(mk(1,1,1,32'h103,1,0,0,1,
                     0,32'hC,0,32'h22222222,32'h4));
    tbl.push_back(mk(1,0,0,0,1,1,32'h00500093,1,
                     0,32'h100,0,32'h22222222,32'h4));
    tbl.push_back(mk(1,0,0,0,1,0,0,1,
                     1,32'h100,0,32'h22222222,32'h4));
    // redirect and response in the same WAIT cycle
    tbl.push_back(mk(1,1,1,32'h200,1,1,32'h33333333,1,
                     0,32'h104,0,32'h22222222,32'h4));
    // not-taken redirects have no effect
    tbl.push_back(mk(1,1,0,32'h500,1,0,0,1,
                     1,32'h200,0,32'h22222222,32'h4));
    tbl.push_back(mk(1,1,0,32'h600,1,1,32'h44444444,1,
                     0,32'h204,0,32'h22222222,32'h4));
    // HOLD stalled 5 cycles, stray response ignored
    tbl.push_back(mk(1,0,0,0,1,0,0,0,
                     0,32'h204,1,32'h44444444,32'h200));
    tbl.push_back(mk(1,0,0,0,1,0,0,0,
                     0,32'h204,1,32'h44444444,32'h200));
    tbl.push_back(mk(1,0,0,0,1,1,32'hDEADBEEF,0,
                     0,32'h204,1,32'h44444444,32'h200));
    tbl.push_back(mk(1,0,0,0,1,0,0,0,
                     0,32'h204,1,32'h44444444,32'h200));
    tbl.push_back(mk(1,0,0,0,1,0,0,0,
                     0,32'h204,1,32'h44444444,32'h200));
    // redirect in HOLD beats inst_ready
    tbl.push_back(mk(1,1,1,32'h40,1,0,0,1,
                     0,32'h204,1,32'h44444444,32'h200));
    // request stall, address held
    tbl.push_back(mk(1,0,0,0,0,0,0,1,
                     1,32'h40,0,32'h44444444,32'h200));
    tbl.push_back(mk(1,0,0,0,0,1,32'hCAFEF00D,1,
                     1,32'h40,0,32'h44444444,32'h200));
    tbl.push_back(mk(1,0,0,0,0,0,0,1,
                     1,32'h40,0,32'h44444444,32'h200));
    tbl.push_back(mk(1,0,0,0,0,0,0,1,
                     1,32'h40,0,32'h44444444,32'h200));
    tbl.push_back(mk(1,1,1,32'h80,0,0,0,1,
                     1,32'h40,0,32'h44444444,32'h200));
    tbl.push_back(mk(1,0,0,0,1,0,0,1,
                     1,32'h80,0,32'h44444444,32'h200));
    tbl.push_back(mk(1,0,0,0,1,1,32'h55555555,1,
                     0,32'h84,0,32'h44444444,32'h200));
    tbl.push_back(mk(1,0,0,0,1,0,0,1,
                     0,32'h84,1,32'h55555555,32'h80));
    // redirect with handshake, misaligned target
    tbl.push_back(mk(1,1,1,32'hFFFFFFFF,1,0,0,1,
                     1,32'h84,0,32'h55555555,32'h80));
    tbl.push_back(mk(1,0,0,0,1,1,32'h66666666,1,
                     0,32'hFFFFFFFC,0,32'h55555555,32'h80));
    tbl.push_back(mk(1,0,0,0,1,0,0,1,
                     1,32'hFFFFFFFC,0,32'h55555555,32'h80));
    // pc wraps to zero
    tbl.push_back(mk(1,0,0,0,1,1,32'h77777777,1,
                     0,32'h0,0,32'h55555555,32'h80));
    tbl.push_back(mk(1,0,0,0,1,0,0,1,
                     0,32'h0,1,32'h77777777,32'hFFFFFFFC));
    tbl.push_back(mk(1,0,0,0,1,0,0,1,
                     1,32'h0,0,32'h77777777,32'hFFFFFFFC));
    // reset in WAIT, late response ignored
    tbl.push_back(mk(0,0,0,0,1,0,0,1,
                     0,32'h4,0,32'h77777777,32'hFFFFFFFC));
    tbl.push_back(mk(1,0,0,0,0,1,32'h88888888,1,
                     1,32'h0,0,32'h0,32'h0));
    tbl.push_back(mk(1,0,0,0,0,0,0,1,
                     1,32'h0,0,32'h0,32'h0));

    reset_n = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.pc_src = 1'b0;
    bus.target_addr = '0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data = '0;
    bus.inst_ready = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      row = i;
      reset_n            = tbl[i].rst;
      bus.redirect_valid = tbl[i].rv;
      bus.pc_src         = tbl[i].ps;
      bus.target_addr    = tbl[i].tgt;
      bus.imem_req_ready = tbl[i].rdy;
      bus.imem_rsp_valid = tbl[i].rspv;
      bus.imem_rsp_data  = tbl[i].rspd;
      bus.inst_ready     = tbl[i].irdy;
      #1;
      chk("req_valid", 32'(bus.imem_req_valid), 32'(tbl[i].e_rqv));
      chk("req_addr", bus.imem_req_addr, tbl[i].e_addr);
      chk("inst_valid", 32'(bus.inst_valid), 32'(tbl[i].e_iv));
      chk("inst", bus.inst, tbl[i].e_inst);
      chk("inst_pc", bus.inst_pc, tbl[i].e_ipc);
    end

    // Throughput: zero-wait memory, 1-cycle response, decode ready.
    @(negedge clk);
    reset_n = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.pc_src = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_req_ready = 1'b1;
    bus.inst_ready = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    pend   = 1'b0;
    paddr  = '0;
    exp_pc = 32'h0;
    nvalid = 0;
    row    = 1000;
    for (int c = 0; c < 9; c++) begin
      if (c > 0) @(negedge clk);
      row = 1000 + c;
      bus.imem_rsp_valid = pend;
      bus.imem_rsp_data  = 32'h1000_0000 + paddr;
      #1;
      if (c == 0) chk("first_req", 32'(bus.imem_req_valid), 32'd1);
      if (bus.inst_valid) begin
        nvalid++;
        chk("tp_inst_pc", bus.inst_pc, exp_pc);
        chk("tp_inst", bus.inst, 32'h1000_0000 + exp_pc);
        exp_pc = exp_pc + 32'd4;
      end
      pend  = bus.imem_req_valid & bus.imem_req_ready;
      paddr = bus.imem_req_addr;
    end
    chk("tp_count", 32'(nvalid), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
